// File: rtl/mask_generation_vga.sv
// -----------------------------------------------------------------------------
// mask_generation_vga
//   Produces one 640-pixel mask row per clock for the VGA mask path.
//   Modes (mask_type):
//     00 slide right : initial row {seed, 0...} rotated right by one per row
//     01 slide left  : initial row {seed, 0...} rotated left by one per row
//     10 random      : 32-bit Fibonacci LFSR, 32 fresh bits enter at pixel 0
//     11 repeated    : W-bit tile of repeatedPattern, emitted once then held
//   The seed arrives serially on `pattern` while load_pattern is high.
//
// Ports
//   clk, rst_n        clock (rising edge) / asynchronous active-low reset
//   clk_en            global enable; low freezes all state, rp_valid goes 0
//   gen_en            generation enable while generating
//   mask_type [1:0]   mode, latched while loading
//   pattern_w [4:0]   tile width 1..8 (0 or >8 means 8), latched while loading
//   pattern           serial seed bit
//   repeatedPattern   tile source, W MSBs used MSB first, latched while loading
//   load_pattern      load strobe (one cycle per seed bit)
//   mg_mask [0:639]   mask row, bit 0 = leftmost pixel
//   rp_valid          high exactly in the cycles mg_mask holds a new row
// -----------------------------------------------------------------------------
module mask_generation_vga #(
    parameter int ROW_W  = 640,
    parameter int SEED_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             gen_en,
    input  logic [1:0]       mask_type,
    input  logic [4:0]       pattern_w,
    input  logic             pattern,
    input  logic [7:0]       repeatedPattern,
    input  logic             load_pattern,
    output logic [0:ROW_W-1] mg_mask,
    output logic             rp_valid
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_PREP = 3'd2,
        S_GEN  = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    // Fibonacci LFSR step for x^32+x^22+x^2+x+1.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    state_t              state_q,  state_d;
    logic [0:SEED_W-1]   seed_q,   seed_d;
    logic [31:0]         lfsr_q,   lfsr_d;
    logic [0:ROW_W-1]    mask_q,   mask_d;
    logic                valid_q,  valid_d;
    logic [1:0]          type_q,   type_d;
    logic [2:0]          wm1_q,    wm1_d;     // tile width minus one
    logic [7:0]          rp_q,     rp_d;

    logic [2:0]          wm1_s;
    logic [31:0]         seed_val_s;
    logic [31:0]         lfsr_n_s;
    logic [0:ROW_W-1]    rp_row_s;

    // Tile row: each pixel picks rp[7 - (i mod W)] from the 8 width candidates.
    for (genvar i = 0; i < ROW_W; i++) begin : g_rp
        logic [7:0] cand_s;
        for (genvar w = 1; w <= 8; w++) begin : g_w
            assign cand_s[w-1] = rp_q[7 - (i % w)];
        end
        assign rp_row_s[i] = cand_s[wm1_q];
    end

    assign lfsr_n_s = lfsr_next(lfsr_q);

    // Seed as a numeric value: seed[k] (k-th most recent bit) is value bit k,
    // so a value sent MSB first lands in the LFSR unchanged.
    always_comb begin
        seed_val_s = 32'd0;
        for (int k = 0; k < 32; k++) begin
            seed_val_s[k] = seed_q[k];
        end
    end

    // Effective tile width: 0 or anything above 8 behaves as 8.
    always_comb begin
        if ((pattern_w == 5'd0) || (pattern_w > 5'd8)) begin
            wm1_s = 3'd7;
        end else begin
            wm1_s = pattern_w[2:0] - 3'd1;
        end
    end

    // Next-state and datapath: a load strobe overrides every state.
    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        lfsr_d  = lfsr_q;
        mask_d  = mask_q;
        valid_d = 1'b0;
        type_d  = type_q;
        wm1_d   = wm1_q;
        rp_d    = rp_q;

        if (load_pattern) begin
            state_d = S_LOAD;
            type_d  = mask_type;
            wm1_d   = wm1_s;
            rp_d    = repeatedPattern;
            if (state_q != S_LOAD) begin
                // first bit of a new load discards the previous seed
                seed_d = {pattern, {(SEED_W-1){1'b0}}};
            end else begin
                seed_d = {pattern, seed_q[0:SEED_W-2]};
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_LOAD: begin
                    state_d = S_PREP;
                end
                S_PREP: begin
                    case (type_q)
                        2'b10: begin
                            // an all-zero LFSR would lock up
                            lfsr_d  = (seed_val_s == 32'd0) ? 32'd1 : seed_val_s;
                            mask_d  = '0;
                            state_d = S_GEN;
                        end
                        2'b11: begin
                            mask_d  = rp_row_s;
                            valid_d = 1'b1;
                            state_d = S_HOLD;
                        end
                        default: begin
                            mask_d  = {seed_q, {(ROW_W-SEED_W){1'b0}}};
                            state_d = S_GEN;
                        end
                    endcase
                end
                S_GEN: begin
                    if (gen_en) begin
                        case (type_q)
                            2'b00: begin
                                mask_d  = {mask_q[ROW_W-1], mask_q[0:ROW_W-2]};
                                valid_d = 1'b1;
                            end
                            2'b01: begin
                                mask_d  = {mask_q[1:ROW_W-1], mask_q[0]};
                                valid_d = 1'b1;
                            end
                            2'b10: begin
                                lfsr_d  = lfsr_n_s;
                                mask_d  = {lfsr_n_s, mask_q[0:ROW_W-SEED_W-1]};
                                valid_d = 1'b1;
                            end
                            default: begin
                                valid_d = 1'b0;
                            end
                        endcase
                    end else begin
                        valid_d = 1'b0;
                    end
                end
                S_HOLD: begin
                    state_d = S_HOLD;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State registers; clk_en low freezes everything but clears rp_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            seed_q  <= '0;
            lfsr_q  <= 32'd0;
            mask_q  <= '0;
            valid_q <= 1'b0;
            type_q  <= 2'b00;
            wm1_q   <= 3'd0;
            rp_q    <= 8'd0;
        end else if (clk_en) begin
            state_q <= state_d;
            seed_q  <= seed_d;
            lfsr_q  <= lfsr_d;
            mask_q  <= mask_d;
            valid_q <= valid_d;
            type_q  <= type_d;
            wm1_q   <= wm1_d;
            rp_q    <= rp_d;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign mg_mask  = mask_q;
    assign rp_valid = valid_q;

endmodule

// File: tb/tb_mask_generation_vga.sv
module tb_mask_generation_vga;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clk_en = 1'b1;
    logic         gen_en = 1'b1;
    logic [1:0]   mask_type = 2'b00;
    logic [4:0]   pattern_w = 5'd0;
    logic         pattern = 1'b0;
    logic [7:0]   repeatedPattern = 8'd0;
    logic         load_pattern = 1'b0;
    logic [0:639] mg_mask;
    logic         rp_valid;

    mask_generation_vga dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clk_en          (clk_en),
        .gen_en          (gen_en),
        .mask_type       (mask_type),
        .pattern_w       (pattern_w),
        .pattern         (pattern),
        .repeatedPattern (repeatedPattern),
        .load_pattern    (load_pattern),
        .mg_mask         (mg_mask),
        .rp_valid        (rp_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [0:639] exp_q[$];
    logic [0:639] mon_exp;

    localparam logic [0:639] RP_EXP   = {160{4'b1010}};
    localparam logic [0:639] SEED_ROW = {32'h8000_0001, 608'b0};

    // ---------------- reference model ----------------
    bit           m_loading, m_prep, m_run;
    bit           m_hist[$];          // index 0 = most recent seed bit
    int           m_mode, m_w, m_cnt;
    logic [7:0]   m_rp;
    logic [31:0]  m_lfsr;
    logic [0:639] m_init, m_row;

    task automatic model_reset();
        m_loading = 1'b0;
        m_prep    = 1'b0;
        m_run     = 1'b0;
        m_hist.delete();
        m_row     = '0;
    endtask

    // Predict the effect of the coming rising edge using the current inputs.
    task automatic model_step();
        logic [0:639] nr;
        logic [31:0]  v;
        bit           fb;
        if (!clk_en) return;
        if (load_pattern) begin
            if (!m_loading) m_hist.delete();
            m_hist.push_front(pattern);
            if (m_hist.size() > 32) void'(m_hist.pop_back());
            m_mode    = int'(mask_type);
            m_w       = (pattern_w == 5'd0 || pattern_w > 5'd8) ? 8 : int'(pattern_w);
            m_rp      = repeatedPattern;
            m_loading = 1'b1;
            m_prep    = 1'b0;
            m_run     = 1'b0;
        end else if (m_loading) begin
            m_loading = 1'b0;
            m_prep    = 1'b1;
        end else if (m_prep) begin
            m_prep = 1'b0;
            v = 32'd0;
            for (int k = 0; k < m_hist.size(); k++) if (m_hist[k]) v[k] = 1'b1;
            if (m_mode == 3) begin
                for (int i = 0; i < 640; i++) nr[i] = m_rp[7 - (i % m_w)];
                m_row = nr;
                exp_q.push_back(nr);
                m_run = 1'b0;
            end else if (m_mode == 2) begin
                m_lfsr = (v == 32'd0) ? 32'd1 : v;
                m_row  = '0;
                m_run  = 1'b1;
            end else begin
                m_init = '0;
                for (int k = 0; k < 32; k++) m_init[k] = v[k];
                m_row = m_init;
                m_cnt = 0;
                m_run = 1'b1;
            end
        end else if (m_run && gen_en) begin
            if (m_mode == 2) begin
                fb     = m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1] ^ m_lfsr[0];
                m_lfsr = {m_lfsr[30:0], fb};
                for (int k = 0; k < 32; k++)  nr[k] = m_lfsr[31 - k];
                for (int j = 0; j < 608; j++) nr[j + 32] = m_row[j];
            end else begin
                m_cnt = (m_cnt + 1) % 640;
                for (int i = 0; i < 640; i++) begin
                    if (m_mode == 0) nr[i] = m_init[(i - m_cnt + 640) % 640];
                    else             nr[i] = m_init[(i + m_cnt) % 640];
                end
            end
            m_row = nr;
            exp_q.push_back(nr);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n && rp_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_row rp_valid=1 got row %h with no row expected", mg_mask);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mg_mask !== mon_exp) begin
                    errors++;
                    $display("FAIL row got %h exp %h", mg_mask, mon_exp);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic jitter();
        mask_type       = 2'($urandom_range(0, 3));
        pattern_w       = 5'($urandom_range(0, 31));
        repeatedPattern = 8'($urandom_range(0, 255));
        pattern         = 1'($urandom_range(0, 1));
    endtask

    task automatic run_cycles(input int n, input bit en_rand);
        for (int i = 0; i < n; i++) begin
            load_pattern = 1'b0;
            jitter();
            clk_en = en_rand ? ($urandom_range(0, 7) != 0) : 1'b1;
            gen_en = en_rand ? ($urandom_range(0, 5) != 0) : 1'b1;
            cyc();
        end
    endtask

    // Shift nbits in, value bit 31 first; bits above 31 are random filler.
    task automatic load_seed(input logic [1:0] mode, input logic [31:0] v, input int nbits,
                             input logic [4:0] pw, input logic [7:0] rp, input bit en_rand);
        for (int b = nbits - 1; b >= 0; b--) begin
            load_pattern    = 1'b1;
            pattern         = (b < 32) ? v[b] : 1'($urandom_range(0, 1));
            mask_type       = mode;
            pattern_w       = pw;
            repeatedPattern = rp;
            clk_en          = en_rand ? ($urandom_range(0, 7) != 0) : 1'b1;
            gen_en          = 1'($urandom_range(0, 1));
            cyc();
        end
        load_pattern = 1'b0;
        clk_en       = 1'b1;
        jitter();
        cyc();
    endtask

    task automatic stop_and_drain(input string name);
        load_pattern = 1'b0;
        clk_en       = 1'b1;
        gen_en       = 1'b0;
        repeat (2) cyc();
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drained_%s pending=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (mg_mask !== '0) begin
            errors++;
            $display("FAIL %s_mask got %h required 0", name, mg_mask);
        end
        checks++;
        if (rp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_valid got %b required 0", name, rp_valid);
        end
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("midreset");
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_pending got %0d required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_row(input string name, input logic [0:639] req);
        checks++;
        if (mg_mask !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", name, mg_mask, req);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // idle without a load: no rows expected
        run_cycles(6, 1'b0);
        stop_and_drain("idle");

        // repeated pattern, W=4, rp=1010_xxxx
        load_seed(2'b11, 32'd0, 1, 5'd4, 8'b1010_0110, 1'b0);
        run_cycles(6, 1'b0);
        stop_and_drain("repeat");
        check_row("repeat_row", RP_EXP);

        // slide right: after PREP and 640 rows the initial row returns
        load_seed(2'b00, 32'h8000_0001, 32, 5'd0, 8'd0, 1'b0);
        run_cycles(641, 1'b0);
        stop_and_drain("slide_right");
        check_row("slide_right_wrap", SEED_ROW);

        // slide left
        load_seed(2'b01, 32'h8000_0001, 32, 5'd0, 8'd0, 1'b0);
        run_cycles(641, 1'b0);
        stop_and_drain("slide_left");
        check_row("slide_left_wrap", SEED_ROW);

        // random with zero seed, 481 rows
        load_seed(2'b10, 32'd0, 32, 5'd0, 8'd0, 1'b0);
        run_cycles(482, 1'b0);
        stop_and_drain("random_zero");

        // enables toggling mid-stream, then a load aborting generation
        load_seed(2'b10, 32'hDEAD_BEEF, 32, 5'd0, 8'd0, 1'b0);
        run_cycles(200, 1'b1);
        load_seed(2'b00, 32'h1234_5678, 32, 5'd0, 8'd0, 1'b0);
        run_cycles(60, 1'b1);
        load_seed(2'b11, 32'd0, 2, 5'd3, 8'hC5, 1'b0);
        run_cycles(4, 1'b1);
        stop_and_drain("enables");

        // randomized episodes: modes, seed lengths, widths 0..31, aborts, resets
        for (int ep = 0; ep < 30; ep++) begin
            load_seed(2'($urandom_range(0, 3)), $urandom, $urandom_range(1, 40),
                      5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)), 1'(ep % 2));
            run_cycles($urandom_range(5, 200), 1'b1);
            if (ep % 3 == 0) stop_and_drain("episode");
            if (ep == 10 || ep == 20) mid_reset();
        end

        stop_and_drain("final");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
